// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream handshake between host byte source and prog_loader
interface prog_loader_if;
  logic       tvalid;
  logic [7:0] tdata;
  logic       tready;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader for the 256x8 processor memory, holds CPU until load completes
// Optional CSUM byte and ERR state enabled by defining LOADER_CSUM_EN.
module prog_loader (
  input  logic         i_clk,
  input  logic         i_rst_n,
  prog_loader_if.slave s_in,
  input  logic         i_load_req,
  output logic         o_mem_we,
  output logic [7:0]   o_mem_addr,
  output logic [7:0]   o_mem_wdata,
  output logic         o_cpu_run,
  output logic [7:0]   o_entry_pc,
  output logic         o_busy,
  output logic         o_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_live;
  logic [7:0] r_addr;
  logic [7:0] r_entry_pc;
  logic [8:0] r_cnt;
  logic       r_mem_we;
  logic [7:0] r_mem_addr;
  logic [7:0] r_mem_wdata;
  logic       w_ready;
  logic       w_accept;
  logic       w_last;

  // r_live keeps tready low until the first edge with reset released.
  assign w_ready  = r_live && (r_state inside {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM});
  assign w_accept = s_in.tvalid && w_ready;
  assign w_last   = (r_cnt == 9'd1);

`ifdef LOADER_CSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_next;

  assign w_sum_next = r_sum + s_in.tdata;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sum <= 8'h00;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        r_sum <= 8'h00;
      end else if (r_state inside {S_ADDR, S_LEN, S_DATA}) begin
        r_sum <= w_sum_next;
      end
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && s_in.tdata == SYNC_BYTE) w_state_next = S_ADDR;
      S_ADDR: if (w_accept) w_state_next = S_LEN;
      S_LEN:  if (w_accept) w_state_next = S_DATA;
      S_DATA: begin
        if (w_accept && w_last) begin
`ifdef LOADER_CSUM_EN
          w_state_next = S_CSUM;
`else
          w_state_next = S_DONE;
`endif
        end
      end
      S_CSUM: begin
`ifdef LOADER_CSUM_EN
        if (w_accept) w_state_next = (w_sum_next == 8'h00) ? S_DONE : S_ERR;
`else
        w_state_next = S_IDLE;
`endif
      end
      S_DONE: if (i_load_req) w_state_next = S_IDLE;
      S_ERR:  if (i_load_req) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_live      <= 1'b0;
      r_addr      <= 8'h00;
      r_entry_pc  <= 8'h00;
      r_cnt       <= 9'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 8'h00;
      r_mem_wdata <= 8'h00;
    end else begin
      r_state  <= w_state_next;
      r_live   <= 1'b1;
      r_mem_we <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_ADDR: begin
            r_addr     <= s_in.tdata;
            r_entry_pc <= s_in.tdata;
          end
          // LEN of zero encodes a full 256-byte payload.
          S_LEN: r_cnt <= (s_in.tdata == 8'h00) ? 9'd256 : {1'b0, s_in.tdata};
          S_DATA: begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= s_in.tdata;
            r_addr      <= r_addr + 8'd1;
            r_cnt       <= r_cnt - 9'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign s_in.tready = w_ready;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_cpu_run   = (r_state == S_DONE);
  assign o_entry_pc  = r_entry_pc;
  assign o_busy      = r_state inside {S_ADDR, S_LEN, S_DATA, S_CSUM};
`ifdef LOADER_CSUM_EN
  assign o_err       = (r_state == S_ERR);
`else
  assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader with a frame-level reference model
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_run;
  logic [7:0] entry_pc;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  prog_loader_if u_if ();

  prog_loader dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .s_in        (u_if),
    .i_load_req  (load_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_cpu_run   (cpu_run),
    .o_entry_pc  (entry_pc),
    .o_busy      (busy),
    .o_err       (err)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_we = 0;
  logic [7:0] tb_mem  [256];
  logic [7:0] ref_mem [256];
  logic [7:0] pl [$];

  // Memory the loader writes into; commits on the edge where mem_we is seen high.
  always @(posedge clk) begin
    if (rst_n && mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
      n_we <= n_we + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit fixed_idle, output bit ok);
    int idle;
    idle = 0;
    if (fixed_idle) begin
      tick();
    end else begin
      while (idle < 4 && int'($urandom_range(99)) < gap_pct) begin
        tick();
        idle++;
      end
    end
    u_if.tvalid = 1'b1;
    u_if.tdata  = b;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      ok = u_if.tready;
      tick();
    end
    u_if.tvalid = 1'b0;
    u_if.tdata  = 8'($urandom);
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic cmp_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", u_if.tready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_entry_pc", entry_pc, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
  endtask

  task automatic run_frame(input logic [7:0] addr, input logic [7:0] len_b, input bit bad,
                           input int gap_pct, input bit fixed_idle);
    int         n;
    int         we0;
    int         wr_bad;
    logic [7:0] sum;
    logic [7:0] csum;
    logic [7:0] a;
    bit         ok;
    bit         expect_done;
    n = (len_b == 8'h00) ? 256 : int'(len_b);
    sum = addr + len_b;
    for (int i = 0; i < n; i++) sum = sum + pl[i];
    csum = 8'h00 - sum;
    if (bad) csum = csum ^ 8'h5A;
    we0 = n_we;
    wr_bad = 0;
    send_byte(8'hA5, gap_pct, fixed_idle, ok);
    check("busy_after_sync", busy, 1);
    send_byte(addr, gap_pct, fixed_idle, ok);
    check("entry_pc_after_addr", entry_pc, addr);
    send_byte(len_b, gap_pct, fixed_idle, ok);
    for (int i = 0; i < n; i++) begin
      a = 8'(int'(addr) + i);
      send_byte(pl[i], gap_pct, fixed_idle, ok);
      if (mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== pl[i]) wr_bad++;
      ref_mem[a] = pl[i];
    end
`ifdef LOADER_CSUM_EN
    send_byte(csum, gap_pct, fixed_idle, ok);
    expect_done = !bad;
`else
    expect_done = 1'b1;
`endif
    check("write_timing", wr_bad, 0);
    check("cpu_run_end", cpu_run, expect_done);
    check("err_end", err, !expect_done);
    check("in_ready_held", u_if.tready, 0);
    check("busy_end", busy, 0);
    check("entry_pc_end", entry_pc, addr);
    tick();
    check("we_pulses", n_we - we0, n);
    cmp_mem("mem_contents");
  endtask

  task automatic rearm();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("rearm_cpu_run", cpu_run, 0);
    check("rearm_err", err, 0);
    check("rearm_in_ready", u_if.tready, 1);
    check("rearm_busy", busy, 0);
  endtask

  initial begin
    bit         ok;
    bit         bad;
    int         nn;
    logic [7:0] b;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] addr;
    logic [7:0] len_b;

    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst_n       = 1'b0;
    load_req    = 1'b0;
    u_if.tvalid = 1'b0;
    u_if.tdata  = 8'h00;
    tick();
    tick();
    tick();
    check_reset_values();
    rst_n = 1'b1;
    tick();
    check("in_ready_after_reset", u_if.tready, 1);

    pl = '{8'hBF, 8'h70};
    run_frame(8'h00, 8'h02, 1'b0, 0, 1'b0);
    rearm();

    pl = '{8'h11, 8'h22, 8'h33};
    run_frame(8'hFE, 8'h03, 1'b0, 0, 1'b0);
    rearm();

`ifdef LOADER_CSUM_EN
    pl = '{8'hBF, 8'h70};
    run_frame(8'h00, 8'h02, 1'b1, 0, 1'b0);
    rearm();
`endif

    send_byte(8'h00, 0, 1'b1, ok);
    check("noise_00_discard", busy, 0);
    send_byte(8'hFF, 0, 1'b1, ok);
    check("noise_ff_discard", busy, 0);
    pl = '{8'h5A};
    run_frame(8'h10, 8'h01, 1'b0, 0, 1'b1);
    rearm();

    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    run_frame(8'h00, 8'h00, 1'b0, 0, 1'b0);
    rearm();

    b0 = 8'($urandom);
    b1 = 8'($urandom);
    send_byte(8'hA5, 0, 1'b0, ok);
    send_byte(8'h30, 0, 1'b0, ok);
    send_byte(8'h04, 0, 1'b0, ok);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("load_req_ignored_busy", busy, 1);
    check("load_req_ignored_run", cpu_run, 0);
    send_byte(b0, 0, 1'b0, ok);
    send_byte(b1, 0, 1'b0, ok);
    ref_mem[8'h30] = b0;
    ref_mem[8'h31] = b1;
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_values();
    rst_n = 1'b1;
    tick();
    check("in_ready_after_midreset", u_if.tready, 1);
    cmp_mem("mem_after_midreset");
    pl = '{8'hAA};
    run_frame(8'h20, 8'h01, 1'b0, 0, 1'b0);
    rearm();

    for (int f = 0; f < 8; f++) begin
      nn = $urandom_range(2);
      for (int k = 0; k < nn; k++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send_byte(b, 30, 1'b0, ok);
      end
      addr  = 8'($urandom);
      len_b = 8'($urandom_range(24, 1));
      pl.delete();
      for (int i = 0; i < int'(len_b); i++) pl.push_back(8'($urandom));
`ifdef LOADER_CSUM_EN
      bad = ($urandom_range(3) == 0);
`else
      bad = 1'b0;
`endif
      run_frame(addr, len_b, bad, $urandom_range(60), 1'b0);
      rearm();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
